mm_sequencer: RTL and testbench

Sequences a full N×N integer matrix multiply C = A·B over the shared 128×32 word operand memory. It uses a single multiply-accumulate processing element (PE) and sits between the top-level matrix-multiply wrapper and the PE. On each accepted start it:
- fetches A[i][k] and B[k][j] from memory;
- streams them into the PE through a valid/ready handshake;
- writes each finished dot product back to memory as C[i][j].

It owns the memory port exclusively while busy.

---
 rtl/mm_sequencer_if.sv | 38 +++
 rtl/mm_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mm_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_sequencer_if.sv
// mm_sequencer_if
//   Groups the operand-memory port and the PE handshake used by mm_sequencer.
//   master : the sequencer side (drives address/strobes/operands)
//   slave  : the memory + PE side (drives read data, ready and accumulator)
// Signals:
//   mem_addr  [ADDR_W] word address         mem_rd_en  read strobe (data next cycle)
//   mem_rdata [DATA_W] read data            mem_wr_en  write strobe
//   mem_wdata [DATA_W] write data           pe_clr     clear PE accumulator
//   pe_valid           operand pair valid   pe_a/pe_b  [DATA_W] operand pair
//   pe_ready           PE accepts the pair  pe_acc     [DATA_W] PE accumulator
interface mm_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic              pe_clr;
  logic              pe_valid;
  logic [DATA_W-1:0] pe_a;
  logic [DATA_W-1:0] pe_b;
  logic              pe_ready;
  logic [DATA_W-1:0] pe_acc;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output pe_clr, pe_valid, pe_a, pe_b,
    input  mem_rdata, pe_ready, pe_acc
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  pe_clr, pe_valid, pe_a, pe_b,
    output mem_rdata, pe_ready, pe_acc
  );
endinterface

// File: rtl/mm_sequencer.sv
// mm_sequencer
//   Sequences C = A*B (N x N, row-major) over a shared word memory using a
//   single multiply-accumulate PE. For each C[i][j] it clears the PE, then for
//   every k reads A[i][k] and B[k][j], hands the pair to the PE, waits one
//   drain cycle and writes the accumulator back to C[i][j].
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      start request (only looked at in IDLE)
//   n [DIM_W]                  matrix dimension, captured on start
//   a_base/b_base/c_base       base word addresses, captured on start
//   busy                       high from the cycle after start through DONE
//   done                       one-cycle pulse when C is complete
//   bus (mm_sequencer_if.master) memory port and PE handshake
module mm_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DIM_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  n,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  output logic              busy,
  output logic              done,
  mm_sequencer_if.master    bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_A  = 3'd1;
  localparam logic [2:0] S_RD_B  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [2:0]        state;
  logic [DIM_W-1:0]  n_q, i_q, j_q, k_q;
  logic [DIM_W-1:0]  n_m1;
  logic [ADDR_W-1:0] a_q, b_q, c_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] pe_a_q, pe_b_q;
  logic              iss_first;

  logic [ADDR_W-1:0] row_i, row_k;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] pe_b_c;

  assign n_m1 = n_q - ONE;

  // Row offsets are at most 6*7 = 42, so the products never need more than
  // ADDR_W bits; the base additions wrap modulo 2^ADDR_W by design.
  assign row_i  = ADDR_W'(i_q) * ADDR_W'(n_q);
  assign row_k  = ADDR_W'(k_q) * ADDR_W'(n_q);
  assign addr_a = a_q + row_i + ADDR_W'(k_q);
  assign addr_b = b_q + row_k + ADDR_W'(j_q);
  assign addr_c = c_q + row_i + ADDR_W'(j_q);

  // Address only changes in access states; otherwise it holds the last value.
  always_comb begin
    mem_addr_c = addr_q;
    case (state)
      S_RD_A:  mem_addr_c = addr_a;
      S_RD_B:  mem_addr_c = addr_b;
      S_WRITE: mem_addr_c = addr_c;
      default: mem_addr_c = addr_q;
    endcase
  end

  assign mem_wdata_c = (state == S_WRITE) ? bus.pe_acc : wdata_q;

  // B arrives on mem_rdata during the first ISSUE cycle; it is passed straight
  // through then and held in pe_b_q for any following stall cycles.
  assign pe_b_c = iss_first ? bus.mem_rdata : pe_b_q;

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_rd_en = (state == S_RD_A) || (state == S_RD_B);
  assign bus.mem_wr_en = (state == S_WRITE);
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.pe_clr    = (state == S_RD_A) && (k_q == '0);
  assign bus.pe_valid  = (state == S_ISSUE);
  assign bus.pe_a      = pe_a_q;
  assign bus.pe_b      = pe_b_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pe_a_q    <= '0;
      pe_b_q    <= '0;
      iss_first <= 1'b0;
    end else begin
      addr_q    <= mem_addr_c;
      wdata_q   <= mem_wdata_c;
      pe_b_q    <= pe_b_c;
      iss_first <= (state == S_RD_B);
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q   <= n;
            a_q   <= a_base;
            b_q   <= b_base;
            c_q   <= c_base;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            state <= (n == '0) ? S_DONE : S_RD_A;
          end
        end
        S_RD_A: state <= S_RD_B;
        S_RD_B: begin
          pe_a_q <= bus.mem_rdata;
          state  <= S_ISSUE;
        end
        S_ISSUE: begin
          if (bus.pe_ready) begin
            k_q   <= k_q + ONE;
            state <= (k_q == n_m1) ? S_DRAIN : S_RD_A;
          end
        end
        S_DRAIN: state <= S_WRITE;
        S_WRITE: begin
          k_q <= '0;
          if (j_q == n_m1) begin
            j_q <= '0;
            if (i_q == n_m1) begin
              state <= S_DONE;
            end else begin
              i_q   <= i_q + ONE;
              state <= S_RD_A;
            end
          end else begin
            j_q   <= j_q + ONE;
            state <= S_RD_A;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer
//   Drives mm_sequencer against a word memory and a two-stage MAC PE, and
//   compares access order, written values, timing and reset behaviour with a
//   reference computed directly from the matrices.
module tb_mm_sequencer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DIM_W  = 3;
  localparam logic [31:0] SENT = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [DIM_W-1:0]  n = '0;
  logic [ADDR_W-1:0] a_base = '0, b_base = '0, c_base = '0;
  logic busy, done;

  mm_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  mm_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy(busy), .done(done), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Memory, loader and PE environment
  logic [31:0] mem [128];
  logic [31:0] rdata_q = '0;
  logic        ld_en = 1'b0;
  logic [6:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ready_drv = 1'b1;
  logic [31:0] prod = '0, acc = '0;
  logic        pend = 1'b0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_en) mem[ld_addr] <= ld_data;
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) rdata_q <= mem[bus.mem_addr];
    if (bus.pe_valid && bus.pe_ready) prod <= bus.pe_a * bus.pe_b;
    pend <= bus.pe_valid && bus.pe_ready;
    if (bus.pe_clr) acc <= '0;
    else if (pend) acc <= acc + prod;
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.pe_ready  = ready_drv;
  assign bus.pe_acc    = acc;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] av [64];
  logic [31:0] bv [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ld(input int a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 7'(a); ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, ":busy0"},  busy, 0);
    chk({nm, ":done0"},  done, 0);
    chk({nm, ":rd0"},    bus.mem_rd_en, 0);
    chk({nm, ":wr0"},    bus.mem_wr_en, 0);
    chk({nm, ":clr0"},   bus.pe_clr, 0);
    chk({nm, ":valid0"}, bus.pe_valid, 0);
    chk({nm, ":addr0"},  bus.mem_addr, 0);
    chk({nm, ":wdata0"}, bus.mem_wdata, 0);
    chk({nm, ":pea0"},   bus.pe_a, 0);
    chk({nm, ":peb0"},   bus.pe_b, 0);
  endtask

  // smode: 0 ready always high, 1 three stall cycles per ISSUE, 2 random stalls
  // poke: cycle at which a foreign start is pulsed (-1 none)
  // rstc: cycle at which reset is asserted (-1 none)
  task automatic run_op(input string nm, input int nn, input int ab, input int bb, input int cb,
                        input int smode, input int poke, input int rstc);
    logic [31:0] cexp [64];
    logic [31:0] sum;
    int rd_q[$];
    int wr_q[$];
    int s, rel, exp_cyc, exp_w;
    int busy_cnt = 0, rd_cnt = 0, wr_cnt = 0, clr_cnt = 0, overlap = 0;
    int stalls = 0, stall_run = 0, done_cyc = -1, w_seen = 0;
    bit stalled_prev = 0, aborted = 0, hold;
    logic [31:0] pa_prev = '0, pb_prev = '0;

    for (int i = 0; i < nn; i++)
      for (int j = 0; j < nn; j++) begin
        sum = '0;
        for (int k = 0; k < nn; k++) begin
          sum = sum + av[i*nn+k] * bv[k*nn+j];
          rd_q.push_back((ab + i*nn + k) % 128);
          rd_q.push_back((bb + k*nn + j) % 128);
        end
        cexp[i*nn+j] = sum;
        wr_q.push_back((cb + i*nn + j) % 128);
      end

    for (int w = 0; w < nn*nn; w++) ld((cb + w) % 128, SENT);
    for (int w = 0; w < nn*nn; w++) ld((ab + w) % 128, av[w]);
    for (int w = 0; w < nn*nn; w++) ld((bb + w) % 128, bv[w]);

    @(negedge clk);
    n = DIM_W'(nn); a_base = 7'(ab); b_base = 7'(bb); c_base = 7'(cb);
    start = 1'b1;
    s = cyc;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      rel = cyc - s;
      if (rel == rstc) begin
        rst_n = 1'b0;
        #1;
        chk_outputs_zero({nm, ":async"});
        for (int h = 0; h < 3; h++) begin
          @(negedge clk);
          chk({nm, ":rst_done"}, done, 0);
          chk({nm, ":rst_rd"}, bus.mem_rd_en, 0);
          chk({nm, ":rst_wr"}, bus.mem_wr_en, 0);
        end
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      start = (rel == poke);
      if (rel == poke) begin
        a_base = 7'(ab + 40); b_base = 7'(bb + 50); c_base = 7'(cb + 60); n = 3'd3;
      end
      if (busy) busy_cnt++;
      if (bus.pe_clr) clr_cnt++;
      if (bus.mem_rd_en && bus.mem_wr_en) overlap++;
      if (bus.mem_rd_en) begin
        rd_cnt++;
        if (rd_q.size() > 0) chk({nm, ":rd_addr"}, bus.mem_addr, rd_q.pop_front());
      end
      if (bus.mem_wr_en) begin
        wr_cnt++;
        if (wr_q.size() > 0) chk({nm, ":wr_addr"}, bus.mem_addr, wr_q.pop_front());
        if (w_seen < nn*nn) chk({nm, ":wdata"}, bus.mem_wdata, cexp[w_seen]);
        w_seen++;
      end
      if (stalled_prev) begin
        chk({nm, ":stall_valid"}, bus.pe_valid, 1);
        chk({nm, ":stall_a"}, bus.pe_a, pa_prev);
        chk({nm, ":stall_b"}, bus.pe_b, pb_prev);
      end
      if (bus.pe_valid) begin
        hold = (smode == 1 && stall_run < 3) || (smode == 2 && $urandom_range(0, 2) == 0);
        ready_drv = !hold;
        if (hold) begin stalls++; stall_run++; end
        stalled_prev = hold;
        pa_prev = bus.pe_a;
        pb_prev = bus.pe_b;
      end else begin
        ready_drv = 1'b1;
        stall_run = 0;
        stalled_prev = 0;
      end
      if (done) begin
        done_cyc = rel;
        break;
      end
    end
    start = 1'b0;
    ready_drv = 1'b1;

    if (!aborted) begin
      exp_cyc = 1 + nn*nn*(3*nn + 2) + stalls;
      chk({nm, ":done_cycle"}, done_cyc, exp_cyc);
      chk({nm, ":busy_cycles"}, busy_cnt, exp_cyc);
      chk({nm, ":reads"}, rd_cnt, 2*nn*nn*nn);
      chk({nm, ":writes"}, wr_cnt, nn*nn);
      chk({nm, ":clears"}, clr_cnt, nn*nn);
      chk({nm, ":overlap"}, overlap, 0);
      @(negedge clk);
      chk({nm, ":busy_after"}, busy, 0);
      chk({nm, ":done_pulse"}, done, 0);
      for (int w = 0; w < nn*nn; w++) chk({nm, ":mem_c"}, mem[(cb + w) % 128], cexp[w]);
    end else begin
      exp_w = (rstc - 1) / (3*nn + 2);
      chk({nm, ":no_done"}, done_cyc, -1);
      chk({nm, ":writes_before_rst"}, w_seen, exp_w);
      for (int w = 0; w < nn*nn; w++)
        chk({nm, ":mem_c_abort"}, mem[(cb + w) % 128], (w < exp_w) ? cexp[w] : SENT);
    end
  endtask

  task automatic load_s1();
    for (int w = 0; w < 4; w++) begin
      av[w] = 32'(w + 1);
      bv[w] = 32'(w + 5);
    end
  endtask

  initial begin
    int nn, ab, bb, cb;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    load_s1();
    run_op("s1", 2, 0, 4, 8, 0, -1, -1);
    chk("s1_c00", mem[8], 19);
    chk("s1_c01", mem[9], 22);
    chk("s1_c10", mem[10], 43);
    chk("s1_c11", mem[11], 50);

    av[0] = 32'd7; bv[0] = 32'd9;
    run_op("n1", 1, 126, 127, 127, 0, -1, -1);
    chk("n1_word127", mem[127], 63);

    load_s1();
    run_op("wrap", 2, 127, 3, 7, 0, -1, -1);

    load_s1();
    run_op("stall3", 2, 0, 4, 8, 1, -1, -1);
    chk("stall3_c11", mem[11], 50);

    run_op("n0", 0, 20, 30, 40, 0, -1, -1);

    load_s1();
    run_op("poke", 2, 0, 4, 8, 0, 10, -1);

    load_s1();
    run_op("abort", 2, 0, 4, 8, 0, -1, 20);
    chk("abort_w8", mem[8], 19);
    chk("abort_w10", mem[10], SENT);

    load_s1();
    run_op("after_rst", 2, 0, 4, 8, 0, -1, -1);

    for (int r = 0; r < 6; r++) begin
      nn = $urandom_range(1, 4);
      ab = $urandom_range(0, 127);
      bb = (ab + nn*nn) % 128;
      cb = (bb + nn*nn) % 128;
      for (int w = 0; w < nn*nn; w++) begin
        av[w] = $urandom;
        bv[w] = $urandom;
      end
      run_op("rand", nn, ab, bb, cb, (r % 2 == 1) ? 2 : 0, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
